// File: rtl/apb_seq_pkg.sv
// rtl/apb_seq_pkg.sv - shared types and policy constants for the APB request sequencer
package apb_seq_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  // When APB_done lands in the same cycle the timeout fires, the real completion is reported.
  localparam bit DONE_WINS_TIMEOUT = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              timeout;
  } rsp_t;

endpackage

// File: rtl/apb_sync_fifo.sv
// rtl/apb_sync_fifo.sv - single-clock FIFO with occupancy count, used for command and response queues
module apb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/apb_req_sequencer.sv
// rtl/apb_req_sequencer.sv - queues host commands, issues them one at a time to the APB master, returns responses
module apb_req_sequencer
  import apb_seq_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_W,
  parameter int DATA_WIDTH     = DATA_W,
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         APB_pclk,
  input  logic                         APB_preset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_WIDTH-1:0]        cmd_addr,
  input  logic [DATA_WIDTH-1:0]        cmd_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_write,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic                         rsp_timeout,
  output logic                         APB_transfer,
  output logic                         APB_rd_wr,
  output logic [ADDR_WIDTH-1:0]        APB_write_addr,
  output logic [DATA_WIDTH-1:0]        APB_write_data,
  output logic [ADDR_WIDTH-1:0]        APB_read_addr,
  input  logic                         APB_done,
  input  logic                         APB_slverr,
  input  logic [DATA_WIDTH-1:0]        APB_read_data,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   cmd_count
);

  localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  seq_state_t               state;
  logic [CNT_W-1:0]         tmo_cnt;
  logic                     cap_write;
  logic                     cap_err;
  logic                     cap_timeout;

  cmd_t                     cmd_in;
  cmd_t                     cmd_head;
  logic                     cmd_push;
  logic                     cmd_pop;
  logic                     cmd_full;
  logic                     cmd_empty;

  rsp_t                     rsp_in;
  rsp_t                     rsp_head;
  logic                     rsp_push;
  logic                     rsp_pop;
  logic                     rsp_full;
  logic                     rsp_empty;
  logic [$clog2(RSP_DEPTH):0] rsp_count;

  logic                     tmo_reached;
  logic                     end_by_done;
  logic                     end_by_tmo;

  assign cmd_in   = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;

  assign tmo_reached = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_W'(TMO_LAST));
  assign end_by_done = (state == WAIT) && APB_done && (DONE_WINS_TIMEOUT || !tmo_reached);
  assign end_by_tmo  = (state == WAIT) && tmo_reached && !end_by_done;
  assign cmd_pop     = end_by_done || end_by_tmo;

  // Read data arrives the cycle after done, which is exactly the CAPTURE cycle.
  assign rsp_push = (state == CAPTURE);
  assign rsp_in   = '{write:   cap_write,
                      rdata:   (cap_write || cap_timeout) ? '0 : APB_read_data,
                      err:     cap_err,
                      timeout: cap_timeout};

  assign rsp_valid   = !rsp_empty;
  assign rsp_pop     = rsp_valid && rsp_ready;
  assign rsp_write   = rsp_head.write;
  assign rsp_rdata   = rsp_head.rdata;
  assign rsp_err     = rsp_head.err;
  assign rsp_timeout = rsp_head.timeout;

  assign busy = (state != IDLE) || !cmd_empty;

  apb_sync_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (APB_pclk),
    .rst       (APB_preset),
    .push      (cmd_push),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .count     (cmd_count)
  );

  apb_sync_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (APB_pclk),
    .rst       (APB_preset),
    .push      (rsp_push),
    .push_data (rsp_in),
    .pop       (rsp_pop),
    .pop_data  (rsp_head),
    .full      (rsp_full),
    .empty     (rsp_empty),
    .count     (rsp_count)
  );

  always_ff @(posedge APB_pclk or posedge APB_preset) begin
    if (APB_preset) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      APB_transfer   <= 1'b0;
      APB_rd_wr      <= 1'b0;
      APB_write_addr <= '0;
      APB_write_data <= '0;
      APB_read_addr  <= '0;
      cap_write      <= 1'b0;
      cap_err        <= 1'b0;
      cap_timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Issuing only with a free response slot guarantees the response FIFO never overflows.
          if (!cmd_empty && !rsp_full) begin
            APB_transfer <= 1'b1;
            APB_rd_wr    <= cmd_head.write;
            tmo_cnt      <= '0;
            state        <= WAIT;
            if (cmd_head.write) begin
              APB_write_addr <= cmd_head.addr;
              APB_write_data <= cmd_head.wdata;
              APB_read_addr  <= '0;
            end else begin
              APB_write_addr <= '0;
              APB_write_data <= '0;
              APB_read_addr  <= cmd_head.addr;
            end
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (end_by_done) begin
            APB_transfer <= 1'b0;
            cap_write    <= APB_rd_wr;
            cap_err      <= APB_slverr;
            cap_timeout  <= 1'b0;
            state        <= CAPTURE;
          end else if (end_by_tmo) begin
            APB_transfer <= 1'b0;
            cap_write    <= APB_rd_wr;
            cap_err      <= 1'b1;
            cap_timeout  <= 1'b1;
            state        <= CAPTURE;
          end
        end
        CAPTURE: begin
          tmo_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_sequencer.sv
// tb/tb_apb_req_sequencer.sv - directed self-checking bench for apb_req_sequencer
module tb_apb_req_sequencer;

  logic        APB_pclk = 1'b0;
  logic        APB_preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        APB_transfer;
  logic        APB_rd_wr;
  logic [7:0]  APB_write_addr;
  logic [15:0] APB_write_data;
  logic [7:0]  APB_read_addr;
  logic        APB_done;
  logic        APB_slverr;
  logic [15:0] APB_read_data;
  logic        busy;
  logic [2:0]  cmd_count;

  int checks = 0;
  int passed = 0;

  apb_req_sequencer #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (16),
    .CMD_DEPTH      (4),
    .RSP_DEPTH      (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .APB_pclk       (APB_pclk),
    .APB_preset     (APB_preset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_write      (rsp_write),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .rsp_timeout    (rsp_timeout),
    .APB_transfer   (APB_transfer),
    .APB_rd_wr      (APB_rd_wr),
    .APB_write_addr (APB_write_addr),
    .APB_write_data (APB_write_data),
    .APB_read_addr  (APB_read_addr),
    .APB_done       (APB_done),
    .APB_slverr     (APB_slverr),
    .APB_read_data  (APB_read_data),
    .busy           (busy),
    .cmd_count      (cmd_count)
  );

  always #5 APB_pclk = ~APB_pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge APB_pclk);
    #1;
  endtask

  task automatic send(input logic w, input logic [7:0] a, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pop_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int   hi;
    int   idx;
    int   k;
    logic fire;
    logic saw_rsp;
    logic saw_xfer;
    logic [7:0]  exp_a;
    logic [31:0] exp_d;

    APB_preset    = 1'b1;
    cmd_valid     = 1'b0;
    cmd_write     = 1'b0;
    cmd_addr      = 8'h00;
    cmd_wdata     = 16'h0000;
    rsp_ready     = 1'b0;
    APB_done      = 1'b0;
    APB_slverr    = 1'b0;
    APB_read_data = 16'h0000;

    // Reset state
    tick();
    tick();
    chk("rst_transfer", 32'(APB_transfer), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_count", 32'(cmd_count), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    APB_preset = 1'b0;
    tick();

    // 1: write 0x22/0xBEEF, done in third WAIT cycle
    send(1'b1, 8'h22, 16'hBEEF);
    chk("w_accept_no_xfer", 32'(APB_transfer), 0);
    chk("w_cmd_count", 32'(cmd_count), 1);
    tick();
    chk("w_xfer_c1", 32'(APB_transfer), 1);
    chk("w_rd_wr", 32'(APB_rd_wr), 1);
    chk("w_waddr", 32'(APB_write_addr), 32'h22);
    chk("w_wdata", 32'(APB_write_data), 32'hBEEF);
    chk("w_raddr", 32'(APB_read_addr), 0);
    chk("w_busy", 32'(busy), 1);
    tick();
    chk("w_xfer_c2", 32'(APB_transfer), 1);
    tick();
    chk("w_xfer_c3", 32'(APB_transfer), 1);
    APB_done = 1'b1;
    tick();
    APB_done = 1'b0;
    chk("w_xfer_drop", 32'(APB_transfer), 0);
    chk("w_no_rsp_yet", 32'(rsp_valid), 0);
    tick();
    chk("w_rsp_valid", 32'(rsp_valid), 1);
    chk("w_rsp_write", 32'(rsp_write), 1);
    chk("w_rsp_rdata", 32'(rsp_rdata), 0);
    chk("w_rsp_err", 32'(rsp_err), 0);
    chk("w_idle_busy", 32'(busy), 0);
    pop_rsp();
    chk("w_popped", 32'(rsp_valid), 0);

    // 2: read 0x22, data 0xBEEF the cycle after done
    send(1'b0, 8'h22, 16'h0000);
    tick();
    chk("r_xfer", 32'(APB_transfer), 1);
    chk("r_rd_wr", 32'(APB_rd_wr), 0);
    chk("r_raddr", 32'(APB_read_addr), 32'h22);
    chk("r_waddr", 32'(APB_write_addr), 0);
    chk("r_wdata", 32'(APB_write_data), 0);
    APB_done = 1'b1;
    tick();
    APB_done = 1'b0;
    APB_read_data = 16'hBEEF;
    tick();
    APB_read_data = 16'h0000;
    chk("r_rsp_valid", 32'(rsp_valid), 1);
    chk("r_rsp_write", 32'(rsp_write), 0);
    chk("r_rsp_rdata", 32'(rsp_rdata), 32'hBEEF);
    chk("r_rsp_err", 32'(rsp_err), 0);
    pop_rsp();

    // 3: read 0x10 with slverr
    send(1'b0, 8'h10, 16'h0000);
    tick();
    APB_done = 1'b1;
    APB_slverr = 1'b1;
    tick();
    APB_done = 1'b0;
    APB_slverr = 1'b0;
    APB_read_data = 16'h1234;
    tick();
    chk("se_rsp_err", 32'(rsp_err), 1);
    chk("se_rsp_timeout", 32'(rsp_timeout), 0);
    chk("se_rsp_rdata", 32'(rsp_rdata), 32'h1234);
    pop_rsp();

    // 4: timeout after 16 WAIT cycles, queued write then issues
    APB_read_data = 16'hFFFF;
    send(1'b0, 8'h30, 16'h0000);
    send(1'b1, 8'h31, 16'h5555);
    hi = (APB_transfer === 1'b1) ? 1 : 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (APB_transfer === 1'b1) hi++;
    end
    chk("to_high_cycles", 32'(hi), 16);
    tick();
    chk("to_xfer_drop", 32'(APB_transfer), 0);
    chk("to_cmd_count", 32'(cmd_count), 1);
    tick();
    chk("to_rsp_valid", 32'(rsp_valid), 1);
    chk("to_rsp_write", 32'(rsp_write), 0);
    chk("to_rsp_rdata", 32'(rsp_rdata), 0);
    chk("to_rsp_err", 32'(rsp_err), 1);
    chk("to_rsp_timeout", 32'(rsp_timeout), 1);
    APB_read_data = 16'h0000;
    pop_rsp();
    chk("to_next_xfer", 32'(APB_transfer), 1);
    chk("to_next_rd_wr", 32'(APB_rd_wr), 1);
    chk("to_next_waddr", 32'(APB_write_addr), 32'h31);
    chk("to_next_wdata", 32'(APB_write_data), 32'h5555);
    APB_done = 1'b1;
    tick();
    APB_done = 1'b0;
    tick();
    chk("to_next_rsp_write", 32'(rsp_write), 1);
    chk("to_next_rsp_err", 32'(rsp_err), 0);
    chk("to_next_rsp_timeout", 32'(rsp_timeout), 0);
    pop_rsp();

    // done in the very cycle the timeout would fire: done wins
    send(1'b0, 8'h44, 16'h0000);
    tick();
    for (int c = 0; c < 15; c++) tick();
    chk("dw_still_high", 32'(APB_transfer), 1);
    APB_done = 1'b1;
    tick();
    APB_done = 1'b0;
    APB_read_data = 16'h7777;
    tick();
    APB_read_data = 16'h0000;
    chk("dw_rsp_err", 32'(rsp_err), 0);
    chk("dw_rsp_timeout", 32'(rsp_timeout), 0);
    chk("dw_rsp_rdata", 32'(rsp_rdata), 32'h7777);
    pop_rsp();

    // 5: back-pressure, 8 commands offered, immediate done
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      cmd_valid = (idx < 8);
      cmd_write = idx[0];
      cmd_addr  = 8'h40 + 8'(idx);
      cmd_wdata = 16'h1000 + 16'(idx);
      APB_done  = APB_transfer;
      APB_read_data = {8'hA5, APB_read_addr};
      fire = cmd_valid && cmd_ready;
      tick();
      if (fire) idx++;
    end
    cmd_valid = 1'b0;
    APB_done = 1'b0;
    chk("bp_accepted", 32'(idx), 6);
    chk("bp_cmd_count", 32'(cmd_count), 4);
    chk("bp_cmd_ready", 32'(cmd_ready), 0);
    chk("bp_rsp_valid", 32'(rsp_valid), 1);
    chk("bp_stalled", 32'(APB_transfer), 0);
    rsp_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 80 && k < 6; c++) begin
      APB_done = APB_transfer;
      APB_read_data = {8'hA5, APB_read_addr};
      if (rsp_valid === 1'b1) begin
        exp_a = 8'h40 + 8'(k);
        exp_d = k[0] ? 32'h0 : {16'h0, 8'hA5, exp_a};
        chk("bp_rsp_write", 32'(rsp_write), 32'(k[0]));
        chk("bp_rsp_rdata", 32'(rsp_rdata), exp_d);
        chk("bp_rsp_err", 32'(rsp_err), 0);
        k++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    APB_done = 1'b0;
    APB_read_data = 16'h0000;
    chk("bp_drained", 32'(k), 6);
    chk("bp_cmd_empty", 32'(cmd_count), 0);
    chk("bp_rsp_empty", 32'(rsp_valid), 0);

    // 6: asynchronous reset mid-WAIT with 3 queued
    send(1'b1, 8'h50, 16'h0A0A);
    send(1'b0, 8'h51, 16'h0000);
    send(1'b1, 8'h52, 16'h0B0B);
    chk("ar_pre_xfer", 32'(APB_transfer), 1);
    chk("ar_pre_count", 32'(cmd_count), 3);
    #2;
    APB_preset = 1'b1;
    #1;
    chk("ar_xfer", 32'(APB_transfer), 0);
    chk("ar_cmd_count", 32'(cmd_count), 0);
    chk("ar_rsp_valid", 32'(rsp_valid), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_cmd_ready", 32'(cmd_ready), 1);
    tick();
    APB_preset = 1'b0;
    APB_done = 1'b1;
    saw_rsp = 1'b0;
    saw_xfer = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
      if (APB_transfer !== 1'b0) saw_xfer = 1'b1;
    end
    APB_done = 1'b0;
    chk("ar_no_rsp", 32'(saw_rsp), 0);
    chk("ar_no_xfer", 32'(saw_xfer), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
